mips_instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: the inverse of the control decoder. Accepts one symbolic instruction per handshake (operation select plus register/immediate fields), packs it into the 32-bit MIPS word whose opcode/funct the decoder recognises, and emits it with a sequential instruction-memory address. It feeds the instruction-memory loader used for self-test and boot-image generation. Output is buffered so full throughput holds under downstream stalls.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mips_instr_encoder_if.sv | 28 ++
 rtl/mips_field_pack.sv | 81 ++++++++
 rtl/mips_instr_encoder.sv | 100 ++++++++++
 tb/tb_mips_instr_encoder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, R-type functs, the encoder's
// operation select, and word-packing helpers for the three instruction formats.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LB    = 6'h20;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_JR, OP_JALR,
    OP_LW, OP_LB, OP_SW, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI,
    OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE, OP_J, OP_JAL
  } op_e;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] shamt,
                                         logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs,
                                         logic [4:0] rt, logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(logic [5:0] opc, logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request/response handshake bundle of the instruction encoder.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/mips_field_pack.sv
// Combinational packer: operation select plus fields -> legal flag and
// 32-bit MIPS word, with the per-instruction field forcing applied.
module mips_field_pack
  import mips_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  logic       is_r;
  logic       is_j;
  logic [5:0] code;

  always_comb begin
    legal = 1'b1;
    is_r  = 1'b0;
    is_j  = 1'b0;
    code  = '0;
    case (op_e'(op))
      OP_ADD:   begin is_r = 1'b1; code = FN_ADD;  end
      OP_ADDU:  begin is_r = 1'b1; code = FN_ADDU; end
      OP_SUB:   begin is_r = 1'b1; code = FN_SUB;  end
      OP_SUBU:  begin is_r = 1'b1; code = FN_SUBU; end
      OP_AND:   begin is_r = 1'b1; code = FN_AND;  end
      OP_OR:    begin is_r = 1'b1; code = FN_OR;   end
      OP_XOR:   begin is_r = 1'b1; code = FN_XOR;  end
      OP_NOR:   begin is_r = 1'b1; code = FN_NOR;  end
      OP_SLL:   begin is_r = 1'b1; code = FN_SLL;  end
      OP_SRL:   begin is_r = 1'b1; code = FN_SRL;  end
      OP_SRA:   begin is_r = 1'b1; code = FN_SRA;  end
      OP_SLT:   begin is_r = 1'b1; code = FN_SLT;  end
      OP_SLTU:  begin is_r = 1'b1; code = FN_SLTU; end
      OP_JR:    begin is_r = 1'b1; code = FN_JR;   end
      OP_JALR:  begin is_r = 1'b1; code = FN_JALR; end
      OP_LW:    code = OPC_LW;
      OP_LB:    code = OPC_LB;
      OP_SW:    code = OPC_SW;
      OP_ADDI:  code = OPC_ADDI;
      OP_ADDIU: code = OPC_ADDIU;
      OP_ANDI:  code = OPC_ANDI;
      OP_ORI:   code = OPC_ORI;
      OP_LUI:   code = OPC_LUI;
      OP_SLTI:  code = OPC_SLTI;
      OP_SLTIU: code = OPC_SLTIU;
      OP_BEQ:   code = OPC_BEQ;
      OP_BNE:   code = OPC_BNE;
      OP_J:     begin is_j = 1'b1; code = OPC_J;   end
      OP_JAL:   begin is_j = 1'b1; code = OPC_JAL; end
      default:  legal = 1'b0;
    endcase
  end

  logic is_shift, is_jr, is_jalr;
  assign is_shift = (op == 5'(OP_SLL)) || (op == 5'(OP_SRL)) || (op == 5'(OP_SRA));
  assign is_jr    = (op == 5'(OP_JR));
  assign is_jalr  = (op == 5'(OP_JALR));

  always_comb begin
    word = '0;
    if (!legal)
      word = '0;
    else if (is_r)
      word = r_word(is_shift ? 5'd0 : rs,
                    (is_jr || is_jalr) ? 5'd0 : rt,
                    is_jr ? 5'd0 : rd,
                    is_shift ? shamt : 5'd0,
                    code);
    else if (is_j)
      word = j_word(code, target);
    else
      word = i_word(code, (op == 5'(OP_LUI)) ? 5'd0 : rs, rt, imm);
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming instruction encoder: two-entry output buffer (output + skid
// register), sequential address assignment, consumed-word counter, sticky err.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  mips_instr_encoder_if.slave bus,
  output logic [CNT_W-1:0] word_count,
  output logic             err
);

  logic        legal;
  logic [31:0] word;

  mips_field_pack u_pack (
    .op     (bus.in_op),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .shamt  (bus.in_shamt),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .legal  (legal),
    .word   (word)
  );

  logic             out_valid_q, skid_valid_q, err_q;
  logic [31:0]      out_instr_q, out_addr_q, skid_instr_q, skid_addr_q, next_addr_q;
  logic [CNT_W-1:0] count_q;
  logic             accept, legal_acc, out_fire, out_free;

  assign bus.in_ready  = !skid_valid_q && !clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign legal_acc     = accept && legal;
  assign out_fire      = out_valid_q && bus.out_ready && !clear;
  assign out_free      = out_fire || !out_valid_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign word_count    = count_q;
  assign err           = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_ADDR;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      next_addr_q  <= BASE_ADDR;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_ADDR;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      next_addr_q  <= BASE_ADDR;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      // Skid is only ever full while in_ready is low, so a skid drain and a
      // new acceptance never coincide.
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_instr_q  <= skid_instr_q;
          out_addr_q   <= skid_addr_q;
          skid_valid_q <= 1'b0;
        end else if (legal_acc) begin
          out_valid_q <= 1'b1;
          out_instr_q <= word;
          out_addr_q  <= next_addr_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (legal_acc) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= word;
        skid_addr_q  <= next_addr_q;
      end
      if (legal_acc)
        next_addr_q <= next_addr_q + 32'd4;
      if (accept && !legal)
        err_q <= 1'b1;
      if (out_fire && (count_q != '1))
        count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed requests push expected
// {instr, addr} pairs; a negedge monitor pops on every output handshake.
module tb_mips_instr_encoder;
  import mips_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] word_count;
  logic        err;

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr = BASE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (reset_n && !clear && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h at 0x%08h, none expected", bus.out_instr, bus.out_addr);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("out_instr", bus.out_instr, e[63:32]);
        check("out_addr", bus.out_addr, e[31:0]);
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                      input logic [25:0] target, input bit legal_op, input logic [31:0] exp_instr);
    bit ok;
    ok = 1'b0;
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = shamt; bus.in_imm = imm; bus.in_target = target;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (legal_op) begin
          sb_q.push_back({exp_instr, exp_addr});
          exp_addr += 32'd4;
        end
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: op %0d not accepted, expected in_ready 1", op);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    sb_q.delete();
    exp_addr = BASE;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0;

    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, BASE);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accepted this cycle, visible next cycle.
    send(5'(OP_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    idle();
    check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    drain("drain_first");

    send(5'(OP_LW),   5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA8_0004);
    send(5'(OP_SLL),  5'd7,  5'd2, 5'd2, 5'd4, 16'h0,    26'h0, 1'b1, 32'h0002_1100);
    send(5'(OP_J),    5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h0100000, 1'b1, 32'h0810_0000);
    send(5'd30,       5'd1,  5'd1, 5'd1, 5'd1, 16'h1,    26'h1, 1'b0, 32'h0);
    send(5'(OP_JR),   5'd31, 5'd5, 5'd6, 5'd7, 16'h0,    26'h0, 1'b1, 32'h03E0_0008);
    send(5'(OP_LUI),  5'd5,  5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3C01_1234);
    send(5'(OP_SUB),  5'd5,  5'd6, 5'd4, 5'd3, 16'h0,    26'h0, 1'b1, 32'h00A6_2022);
    send(5'(OP_BEQ),  5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h1022_FFFF);
    send(5'(OP_JALR), 5'd4,  5'd3, 5'd31, 5'd2, 16'h0,   26'h0, 1'b1, 32'h0080_F809);
    idle();
    drain("drain_mix");
    check("err_sticky", {31'd0, err}, 32'd1);
    check("count_mix", {16'd0, word_count}, 32'd9);

    // Clear with two words buffered and a request pending.
    bus.out_ready = 1'b0;
    send(5'(OP_OR),  5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0);
    send(5'(OP_XOR), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0);
    bus.in_op = 5'(OP_AND);
    pulse_clear();
    idle();
    check("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_count", {16'd0, word_count}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    bus.out_ready = 1'b1;
    send(5'(OP_ADDIU), 5'd2, 5'd3, 5'd0, 5'd0, 16'h8000, 26'h0, 1'b1, 32'h2443_8000);
    idle();
    drain("drain_after_clear");
    pulse_clear();

    // Backpressure: skid absorbs one, then in_ready drops and output holds.
    bus.out_ready = 1'b0;
    send(5'(OP_ADD), 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0021_0820);
    send(5'(OP_NOR), 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0042_1027);
    idle();
    @(negedge clk);
    check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("stall_hold_instr", bus.out_instr, 32'h0021_0820);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_hold_addr", bus.out_addr, BASE);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(5'(OP_JAL), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h0FFF_FFFF);
    idle();
    drain("drain_stall");
    check("count_stall", {16'd0, word_count}, 32'd3);

    // Asynchronous reset mid-stream drops everything buffered.
    bus.out_ready = 1'b0;
    send(5'(OP_SW), 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h0);
    send(5'(OP_BNE), 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h0);
    idle();
    #2 reset_n = 1'b0;
    #1;
    sb_q.delete();
    exp_addr = BASE;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_out_addr", bus.out_addr, BASE);
    check("arst_count", {16'd0, word_count}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(5'(OP_ORI), 5'd9, 5'd10, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b1, 32'h352A_BEEF);
    idle();
    drain("drain_after_reset");
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
